// File: rtl/lanectrl_pause_sequencer_if.sv
// Update handshake and lane delay-line signals of the pause sequencer.
// UPD_COUNT exists only when LANECTRL_PAUSE_SEQ_CNT_EN is defined.
interface lanectrl_pause_sequencer_if #(
    parameter int STEP_W = 4
);
    logic              UPD_REQ;
    logic              UPD_DIR;
    logic [STEP_W-1:0] UPD_STEPS;
    logic              UPD_ACK;
    logic              UPD_BUSY;
    logic              HS_IO_CLK_PAUSE;
    logic              DELAY_MOVE;
    logic              DELAY_DIR;
`ifdef LANECTRL_PAUSE_SEQ_CNT_EN
    logic [15:0]       UPD_COUNT;
`endif

    // Request side: UPD_REQ is a level held until the one-cycle UPD_ACK pulse,
    // UPD_DIR/UPD_STEPS are only sampled in the cycle the request is accepted,
    // and UPD_REQ must be dropped in the cycle after UPD_ACK.
    modport master (
        output UPD_REQ, UPD_DIR, UPD_STEPS,
        input  UPD_ACK, UPD_BUSY, HS_IO_CLK_PAUSE, DELAY_MOVE, DELAY_DIR
`ifdef LANECTRL_PAUSE_SEQ_CNT_EN
        , input UPD_COUNT
`endif
    );

    modport slave (
        input  UPD_REQ, UPD_DIR, UPD_STEPS,
        output UPD_ACK, UPD_BUSY, HS_IO_CLK_PAUSE, DELAY_MOVE, DELAY_DIR
`ifdef LANECTRL_PAUSE_SEQ_CNT_EN
        , output UPD_COUNT
`endif
    );
endinterface

// File: rtl/lanectrl_pause_sequencer.sv
// Brackets each lane delay-line move with a clock-pause window (pre-guard, move, post-guard)
// and enforces a gap between windows. Optional completed-update counter: LANECTRL_PAUSE_SEQ_CNT_EN.
module lanectrl_pause_sequencer #(
    parameter int PRE_CYCLES  = 2,
    parameter int POST_CYCLES = 3,
    parameter int GAP_CYCLES  = 4,
    parameter int STEP_W      = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    lanectrl_pause_sequencer_if.slave   bus,
    output logic [2:0]                  dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_MOVE = 3'd2,
        S_POST = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [7:0] PRE_LD  = 8'(PRE_CYCLES - 1);
    localparam logic [7:0] POST_LD = 8'(POST_CYCLES - 1);
    // GAP also covers the ACK cycle, so it loads the full count rather than count-1.
    localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES);

    state_t            state_q, state_d;
    logic [7:0]        phase_q, phase_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              dir_q, dir_d;
    logic              pause_q, pause_d;
    logic              move_q, move_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            step_q  <= '0;
            dir_q   <= 1'b0;
            pause_q <= 1'b0;
            move_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            pause_q <= pause_d;
            move_q  <= move_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        step_d  = step_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.UPD_REQ) begin
                    if (bus.UPD_STEPS != '0) begin
                        state_d = S_PRE;
                        phase_d = PRE_LD;
                        step_d  = bus.UPD_STEPS;
                        dir_d   = bus.UPD_DIR;
                    end else begin
                        state_d = S_GAP;
                        phase_d = GAP_LD;
                    end
                end
            end
            S_PRE: begin
                if (phase_q == 8'd0) state_d = S_MOVE;
                else                 phase_d = phase_q - 8'd1;
            end
            S_MOVE: begin
                if (step_q == STEP_W'(1)) begin
                    state_d = S_POST;
                    phase_d = POST_LD;
                end else begin
                    step_d = step_q - STEP_W'(1);
                end
            end
            S_POST: begin
                if (phase_q == 8'd0) begin
                    state_d = S_GAP;
                    phase_d = GAP_LD;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_GAP: begin
                if (phase_q == 8'd0) state_d = S_IDLE;
                else                 phase_d = phase_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        pause_d = 1'b0;
        move_d  = 1'b0;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        pause_d = (state_d == S_PRE) || (state_d == S_MOVE) || (state_d == S_POST);
        move_d  = (state_d == S_MOVE);
        ack_d   = (state_d == S_GAP) && (state_q != S_GAP);
        busy_d  = (state_d != S_IDLE);
    end

    assign bus.UPD_ACK         = ack_q;
    assign bus.UPD_BUSY        = busy_q;
    assign bus.HS_IO_CLK_PAUSE = pause_q;
    assign bus.DELAY_MOVE      = move_q;
    assign bus.DELAY_DIR       = dir_q;
    assign dbg_state           = state_q;

`ifdef LANECTRL_PAUSE_SEQ_CNT_EN
    logic [15:0] upd_count_q;
    logic        paused_ack_d;

    // Only updates that actually paused the clock are counted.
    assign paused_ack_d = (state_q == S_POST) && (state_d == S_GAP);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                                         upd_count_q <= '0;
        else if (paused_ack_d && (upd_count_q != 16'hFFFF)) upd_count_q <= upd_count_q + 16'd1;
    end

    assign bus.UPD_COUNT = upd_count_q;
`endif
endmodule

// File: tb/tb_lanectrl_pause_sequencer.sv
// Self-checking bench for lanectrl_pause_sequencer: cycle-exact window checks plus a
// scoreboard of expected {dir, steps} entries consumed on each UPD_ACK.
module tb_lanectrl_pause_sequencer;
    localparam int PRE    = 2;
    localparam int POST   = 3;
    localparam int GAP    = 4;
    localparam int STEP_W = 4;
    localparam int W      = STEP_W + 1;

    logic       CLK;
    logic       RESET;
    logic [2:0] dbg_state;

    lanectrl_pause_sequencer_if #(.STEP_W(STEP_W)) bus ();

    lanectrl_pause_sequencer #(
        .PRE_CYCLES (PRE),
        .POST_CYCLES(POST),
        .GAP_CYCLES (GAP),
        .STEP_W     (STEP_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    int n_acks   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h required %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic start_req(input logic dir, input logic [STEP_W-1:0] steps);
        bus.UPD_REQ   = 1'b1;
        bus.UPD_DIR   = dir;
        bus.UPD_STEPS = steps;
        exp_q.push_back({dir, steps});
    endtask

    task automatic wait_ack();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLK);
            if (bus.UPD_ACK) begin
                seen = 1'b1;
                bus.UPD_REQ = 1'b0;
            end
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            if (!bus.UPD_BUSY) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_move();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            if (bus.DELAY_MOVE) seen = 1'b1;
        end
        if (!seen) check("move_timeout", 32'd0, 32'd1);
    endtask

    // scoreboard monitor: accumulates each pause window, compares on UPD_ACK
    int           plen;
    int           mcnt;
    logic         viol;
    logic         dchg;
    logic         dfirst;
    logic [W-1:0] e;
    int           e_steps;

    always @(negedge CLK) begin
        if (RESET) begin
            plen = 0; mcnt = 0; viol = 1'b0; dchg = 1'b0;
        end else begin
            if (bus.HS_IO_CLK_PAUSE) begin
                if (plen == 0) dfirst = bus.DELAY_DIR;
                else if (bus.DELAY_DIR !== dfirst) dchg = 1'b1;
                plen++;
            end
            if (bus.DELAY_MOVE) begin
                mcnt++;
                if (!bus.HS_IO_CLK_PAUSE) viol = 1'b1;
            end
            if (bus.UPD_ACK) begin
                n_acks++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    e_steps = int'(e[STEP_W-1:0]);
                    check("sb_moves", mcnt, e_steps);
                    check("sb_pause_len", plen, (e_steps == 0) ? 0 : PRE + e_steps + POST);
                    check("sb_ack_pause_low", bus.HS_IO_CLK_PAUSE, 32'd0);
                    check("sb_dir_stable", dchg, 32'd0);
                    check("sb_move_in_pause", viol, 32'd0);
                    if (e_steps != 0) check("sb_dir", dfirst, e[STEP_W]);
                end
                plen = 0; mcnt = 0; viol = 1'b0; dchg = 1'b0;
            end
        end
    end

    int n;
    int acks_before;

    initial begin
        RESET = 1'b1;
        bus.UPD_REQ = 1'b0;
        bus.UPD_DIR = 1'b0;
        bus.UPD_STEPS = '0;
        repeat (3) @(negedge CLK);
        check("rst_pause", bus.HS_IO_CLK_PAUSE, 32'd0);
        check("rst_busy", bus.UPD_BUSY, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_state", dbg_state, 32'd0);
        check("rst_ack", bus.UPD_ACK, 32'd0);
        check("rst_move", bus.DELAY_MOVE, 32'd0);
        check("rst_dir", bus.DELAY_DIR, 32'd0);

        // cycle-exact window: STEPS=5, DIR=1 accepted at cycle 0
        start_req(1'b1, 4'd5);
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            check("t1_pause", bus.HS_IO_CLK_PAUSE, (k >= 1 && k <= 10));
            check("t1_move", bus.DELAY_MOVE, (k >= 3 && k <= 7));
            check("t1_ack", bus.UPD_ACK, (k == 11));
            check("t1_busy", bus.UPD_BUSY, (k <= 15));
            if (k == 5) check("t1_dir", bus.DELAY_DIR, 32'd1);
            if (k == 11) bus.UPD_REQ = 1'b0;
        end

        // zero-step request: ACK at cycle 1, no pause, next acceptance at cycle 6
        start_req(1'b0, 4'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                check("t2_ack", bus.UPD_ACK, 32'd1);
                bus.UPD_REQ = 1'b0;
            end
            if (k >= 1 && k <= 6) begin
                check("t2_pause", bus.HS_IO_CLK_PAUSE, 32'd0);
                check("t2_move", bus.DELAY_MOVE, 32'd0);
            end
            if (k == 2) start_req(1'b1, 4'd3);
            if (k == 5) check("t2_busy_gap", bus.UPD_BUSY, 32'd1);
            if (k == 6) check("t2_busy_idle", bus.UPD_BUSY, 32'd0);
            if (k == 7) check("t2_pause_rise", bus.HS_IO_CLK_PAUSE, 32'd1);
        end
        wait_ack();
        wait_idle();

        // request held through ACK and GAP: restart GAP+1 cycles after ACK
        start_req(1'b1, 4'd2);
        exp_q.push_back({1'b1, 4'd2});
        begin : held
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge CLK);
                if (bus.UPD_ACK) seen = 1'b1;
            end
            if (!seen) check("held_ack_timeout", 32'd0, 32'd1);
        end
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            n++;
            if (bus.HS_IO_CLK_PAUSE) break;
        end
        check("held_restart", n, GAP + 2);
        check("held_low_gap_ge4", (n - 1) >= 4, 32'd1);
        bus.UPD_REQ = 1'b0;
        wait_ack();
        wait_idle();

        // direction/steps changed mid-move are ignored
        start_req(1'b0, 4'd6);
        wait_move();
        bus.UPD_DIR = 1'b1;
        bus.UPD_STEPS = 4'd2;
        wait_ack();
        wait_idle();

        // reset during the second move strobe
        start_req(1'b1, 4'd5);
        wait_move();
        @(posedge CLK);
        #1;
        acks_before = n_acks;
        RESET = 1'b1;
        #1;
        check("rst_mid_pause", bus.HS_IO_CLK_PAUSE, 32'd0);
        check("rst_mid_move", bus.DELAY_MOVE, 32'd0);
        check("rst_mid_busy", bus.UPD_BUSY, 32'd0);
        check("rst_mid_ack", bus.UPD_ACK, 32'd0);
        void'(exp_q.pop_back());
        bus.UPD_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_mid_no_ack", n_acks, acks_before);
        start_req(1'b0, 4'd3);
        wait_ack();
        wait_idle();

        // random updates, including zero and maximum step counts
        for (int i = 0; i < 8; i++) begin
            start_req(1'($urandom_range(0, 1)), STEP_W'($urandom_range(0, 15)));
            wait_ack();
            wait_idle();
        end
        start_req(1'b1, 4'd15);
        wait_ack();
        wait_idle();

`ifdef LANECTRL_PAUSE_SEQ_CNT_EN
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("cnt_reset", bus.UPD_COUNT, 32'd0);
        start_req(1'b1, 4'd1);  wait_ack(); wait_idle();
        start_req(1'b0, 4'd0);  wait_ack(); wait_idle();
        start_req(1'b1, 4'd15); wait_ack(); wait_idle();
        check("cnt_two", bus.UPD_COUNT, 32'd2);
        force dut.upd_count_q = 16'hFFFF;
        @(negedge CLK);
        release dut.upd_count_q;
        start_req(1'b0, 4'd2); wait_ack(); wait_idle();
        check("cnt_saturate", bus.UPD_COUNT, 32'hFFFF);
`endif

        check("sb_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
